pipe_hazard_ctrl: RTL and testbench

- Pipeline interlock and flush sequencer for the 5-stage MIPS core.
- Sits beside the decode-stage control unit and consumes its decoded Jump/MemRead/RegWrite fields plus register indices.
- Drives PC/IF-ID write enables, IF-ID flush, ID-EX bubble insertion and EX-MEM hold.
- Handles load-use stalls, JR-after-load stalls, taken-branch/jump flushes and data-memory wait states with a timeout.

---
 rtl/pipe_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline interlock / flush sequencer for the 5-stage MIPS core.
// Optional stall_cycles performance counter is built only when HAZARD_STALL_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [1:0]       id_jump,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, JR_WAIT, MEM_WAIT} state_t;

  localparam logic [9:0] TMO = 10'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [9:0] timer, timer_nxt;
  logic       mem_wait, match, load_use, jr_load, is_jump;
  logic       pc_w, ifid_w, flush, bubble, hold;

  assign mem_wait = mem_req && !mem_ready;
  assign match    = (ex_rd != 5'd0) &&
                    ((id_uses_rs && (ex_rd == id_rs)) || (id_uses_rt && (ex_rd == id_rt)));
  assign load_use = ex_mem_read && ex_reg_write && match;
  assign jr_load  = (id_jump == 2'b10) && ex_mem_read && (ex_rd == id_rs) && (ex_rd != 5'd0);
  assign is_jump  = (id_jump == 2'b01) || (id_jump == 2'b10);

  always_comb begin
    pc_w      = 1'b1;
    ifid_w    = 1'b1;
    flush     = 1'b0;
    bubble    = 1'b0;
    hold      = 1'b0;
    state_nxt = state;
    timer_nxt = timer;
    case (state)
      RUN: begin
        if (mem_wait) begin
          pc_w      = 1'b0;
          ifid_w    = 1'b0;
          hold      = 1'b1;
          state_nxt = MEM_WAIT;
          timer_nxt = 10'd1;
        end else if (ex_branch_taken) begin
          flush  = 1'b1;
          bubble = 1'b1;
        end else if (load_use) begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          bubble = 1'b1;
        end else if (jr_load) begin
          pc_w      = 1'b0;
          ifid_w    = 1'b0;
          bubble    = 1'b1;
          state_nxt = JR_WAIT;
        end else if (is_jump) begin
          flush = 1'b1;
        end
      end
      JR_WAIT: begin
        pc_w   = 1'b0;
        ifid_w = 1'b0;
        if (mem_wait) begin
          hold      = 1'b1;
          state_nxt = MEM_WAIT;
          timer_nxt = 10'd1;
        end else begin
          // second JR stall: load data becomes forwardable from WB next cycle
          bubble    = 1'b1;
          state_nxt = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_wait) begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          hold   = 1'b1;
          if (timer != TMO) timer_nxt = timer + 10'd1;
        end else begin
          // ready, or request withdrawn: either way the access is over
          state_nxt = RUN;
          timer_nxt = 10'd0;
        end
      end
      default: begin
        state_nxt = RUN;
        timer_nxt = 10'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      timer       <= 10'd0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      if (state_nxt == MEM_WAIT && timer_nxt == TMO) mem_timeout <= 1'b1;
    end
  end

  assign pc_write    = rst ? 1'b1 : pc_w;
  assign ifid_write  = rst ? 1'b1 : ifid_w;
  assign ifid_flush  = rst ? 1'b0 : flush;
  assign idex_bubble = rst ? 1'b0 : bubble;
  assign exmem_hold  = rst ? 1'b0 : hold;

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (!pc_write) stall_cnt <= stall_cnt + 1'b1;
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl; a second instance uses MEM_TIMEOUT=4.
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_STALL_CNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic        clk, rst;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rs, id_uses_rt, ex_mem_read, ex_reg_write, ex_branch_taken;
  logic [1:0]  id_jump;
  logic        mem_req, mem_ready;

  logic        pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, mem_timeout;
  logic [15:0] stall_cycles;
  logic        t_pc_write, t_ifid_write, t_ifid_flush, t_idex_bubble, t_exmem_hold, t_mem_timeout;
  logic [15:0] t_stall_cycles;

  logic [4:0]  outs, t_outs;
  int          checks, failures;

  assign outs   = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold};
  assign t_outs = {t_pc_write, t_ifid_write, t_ifid_flush, t_idex_bubble, t_exmem_hold};

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_jump(id_jump), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_hold(exmem_hold),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut_to (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_jump(id_jump), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_write(t_pc_write), .ifid_write(t_ifid_write),
    .ifid_flush(t_ifid_flush), .idex_bubble(t_idex_bubble), .exmem_hold(t_exmem_hold),
    .mem_timeout(t_mem_timeout), .stall_cycles(t_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // outs order: {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold}
  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_jump = 2'b00;
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    mem_req = 1'b1; ex_rd = 5'd8; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
    id_rs = 5'd8; id_uses_rs = 1'b1;
    tick(); tick(); #3;
    checks++;
    if (outs !== 5'b11000) begin
      failures++; $display("FAIL reset_outs actual=%b required=%b", outs, 5'b11000);
    end
    checks++;
    if (mem_timeout !== 1'b0 || stall_cycles !== 16'd0) begin
      failures++; $display("FAIL reset_regs actual=%b/%0d required=0/0", mem_timeout, stall_cycles);
    end
    tick();
    rst = 1'b0;
    idle();
    #3;
    checks++;
    if (outs !== 5'b11000) begin
      failures++; $display("FAIL reset_release actual=%b required=%b", outs, 5'b11000);
    end
  endtask

  task automatic test_load_use();
    reset_dut();
    ex_rd = 5'd8; ex_mem_read = 1'b1; ex_reg_write = 1'b1; id_rs = 5'd8; id_uses_rs = 1'b1;
    #3;
    checks++;
    if (outs !== 5'b00010) begin
      failures++; $display("FAIL load_use_stall actual=%b required=%b", outs, 5'b00010);
    end
    tick();
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_reg_write = 1'b0;
    #3;
    checks++;
    if (outs !== 5'b11000) begin
      failures++; $display("FAIL load_use_resume actual=%b required=%b", outs, 5'b11000);
    end
    tick();
    checks++;
    if (stall_cycles !== 16'(CNT_EN * 1)) begin
      failures++; $display("FAIL load_use_count actual=%0d required=%0d", stall_cycles, CNT_EN);
    end
    // rt hazard; then rs match with use bit clear must not stall
    ex_rd = 5'd9; ex_mem_read = 1'b1; ex_reg_write = 1'b1; id_rt = 5'd9; id_uses_rt = 1'b1;
    #3;
    checks++;
    if (outs !== 5'b00010) begin
      failures++; $display("FAIL load_use_rt actual=%b required=%b", outs, 5'b00010);
    end
    tick();
    id_rt = 5'd0; id_uses_rt = 1'b0; id_rs = 5'd9; id_uses_rs = 1'b0;
    #3;
    checks++;
    if (outs !== 5'b11000) begin
      failures++; $display("FAIL load_use_nouse actual=%b required=%b", outs, 5'b11000);
    end
    tick();
  endtask

  task automatic test_load_zero();
    reset_dut();
    ex_rd = 5'd0; ex_mem_read = 1'b1; ex_reg_write = 1'b1; id_rs = 5'd0; id_uses_rs = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #3;
      checks++;
      if (outs !== 5'b11000) begin
        failures++; $display("FAIL load_zero_%0d actual=%b required=%b", i, outs, 5'b11000);
      end
      tick();
    end
    checks++;
    if (stall_cycles !== 16'd0) begin
      failures++; $display("FAIL load_zero_count actual=%0d required=0", stall_cycles);
    end
  endtask

  task automatic test_jr_load();
    reset_dut();
    ex_rd = 5'd31; ex_mem_read = 1'b1; ex_reg_write = 1'b1; id_jump = 2'b10; id_rs = 5'd31;
    #3;
    checks++;
    if (outs !== 5'b00010) begin
      failures++; $display("FAIL jr_stall1 actual=%b required=%b", outs, 5'b00010);
    end
    tick();
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_reg_write = 1'b0;
    #3;
    checks++;
    if (outs !== 5'b00010) begin
      failures++; $display("FAIL jr_stall2 actual=%b required=%b", outs, 5'b00010);
    end
    tick();
    #3;
    checks++;
    if (outs !== 5'b11100) begin
      failures++; $display("FAIL jr_flush actual=%b required=%b", outs, 5'b11100);
    end
    tick();
    checks++;
    if (stall_cycles !== 16'(CNT_EN * 2)) begin
      failures++; $display("FAIL jr_count actual=%0d required=%0d", stall_cycles, CNT_EN * 2);
    end
  endtask

  task automatic test_jump();
    reset_dut();
    id_jump = 2'b01;
    #3;
    checks++;
    if (outs !== 5'b11100) begin
      failures++; $display("FAIL jump_j actual=%b required=%b", outs, 5'b11100);
    end
    tick();
    id_jump = 2'b11;
    #3;
    checks++;
    if (outs !== 5'b11000) begin
      failures++; $display("FAIL jump_reserved actual=%b required=%b", outs, 5'b11000);
    end
    tick();
  endtask

  task automatic test_branch_vs_hazard();
    reset_dut();
    ex_rd = 5'd8; ex_mem_read = 1'b1; ex_reg_write = 1'b1; id_rs = 5'd8; id_uses_rs = 1'b1;
    ex_branch_taken = 1'b1;
    #3;
    checks++;
    if (outs !== 5'b11110) begin
      failures++; $display("FAIL branch_flush actual=%b required=%b", outs, 5'b11110);
    end
    tick();
    checks++;
    if (stall_cycles !== 16'd0) begin
      failures++; $display("FAIL branch_count actual=%0d required=0", stall_cycles);
    end
  endtask

  task automatic test_mem_wait();
    reset_dut();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ex_branch_taken = (i == 2);
      #3;
      checks++;
      if (outs !== 5'b00001) begin
        failures++; $display("FAIL mem_wait_%0d actual=%b required=%b", i, outs, 5'b00001);
      end
      tick();
    end
    ex_branch_taken = 1'b0;
    mem_ready = 1'b1;
    #3;
    checks++;
    if (outs !== 5'b11000) begin
      failures++; $display("FAIL mem_release actual=%b required=%b", outs, 5'b11000);
    end
    tick();
    idle();
    #3;
    checks++;
    if (stall_cycles !== 16'(CNT_EN * 5) || mem_timeout !== 1'b0) begin
      failures++;
      $display("FAIL mem_count actual=%0d/%b required=%0d/0", stall_cycles, mem_timeout, CNT_EN * 5);
    end
    tick();
  endtask

  task automatic test_timeout_reset();
    reset_dut();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      #3;
      checks++;
      if (t_mem_timeout !== (i >= 4)) begin
        failures++; $display("FAIL timeout_edge%0d actual=%b required=%b", i, t_mem_timeout, (i >= 4));
      end
    end
    checks++;
    if (mem_timeout !== 1'b0 || t_outs !== 5'b00001) begin
      failures++; $display("FAIL timeout_hold actual=%b/%b required=0/00001", mem_timeout, t_outs);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (t_outs !== 5'b11000 || t_mem_timeout !== 1'b0) begin
      failures++; $display("FAIL async_reset actual=%b/%b required=11000/0", t_outs, t_mem_timeout);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (t_outs !== 5'b00001 || t_mem_timeout !== 1'b0) begin
      failures++; $display("FAIL post_reset_run actual=%b/%b required=00001/0", t_outs, t_mem_timeout);
    end
    idle();
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_load_zero();
    test_jr_load();
    test_jump();
    test_branch_vs_hazard();
    test_mem_wait();
    test_timeout_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
